adder_settle_monitor: RTL
=========================

# adder_settle_monitor

Synthesizable downstream stage for the 3-bit adder characterization flow. It consumes the gate-level adder outputs and measures, in clock cycles, how long they take to settle against the RTL golden result after each input transition. It tracks the worst-case settle count with the from/to input codes that caused it, and counts vectors that never settle. It replaces the `$time%100` bookkeeping of the transition-sweep bench with clocked hardware that can sit next to the adders on an FPGA.

## Interface
Parameters:
- `WIDTH`, 3: adder operand width; input code is `{a,b,c0}`, 2*WIDTH+1 bits.
- `WINDOW`, 15: sample cycles per launched vector; 1..2^CNT_W-1.
- `CNT_W`, 4: width of the settle counters.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `launch`  in  1  new input code applied to the adders this cycle.
- `launch_code`  in  2*WIDTH+1  `{a,b,c0}` just applied.
- `ref_sum`  in  WIDTH+1  golden `{c_out,s}` from the RTL adder.
- `dut_sum`  in  WIDTH+1  `{c_out,s}` from the gate-level adder.
- `busy`  out  1  measurement window in progress.
- `done`  out  1  one-cycle pulse; result valid.
- `settle_cycles`  out  CNT_W  settle count of the last completed vector.
- `timeout`  out  1  last completed vector ended mismatched.
- `max_settle`  out  CNT_W  worst settle count since reset.
- `max_from`, `max_to`  out  2*WIDTH+1 each  transition codes for `max_settle`.
- `err_count`  out  16  number of timed-out vectors, saturating at 0xFFFF.
- `glitch_cnt`  out  CNT_W  `dut_sum` changes in the last window (see Configuration).

## Operation
- **Reset:**
  - All outputs are 0 and the FSM is in IDLE.
  - The internal `prev_code` and `cur_code` registers are 0.
- **FSM states:** IDLE, TRACK, DONE.
  - IDLE→TRACK on `launch`.
  - TRACK→DONE after sample k=WINDOW.
  - DONE→TRACK on `launch`, otherwise DONE→IDLE.
- **Launch** is accepted in any state:
  - `prev_code <= cur_code`, `cur_code <= launch_code`.
  - Sample index k is reset to 0 and `last_bad` to 0.
- **TRACK sampling:**
  - Each cycle k increments; k runs 1..WINDOW.
  - If `dut_sum != ref_sum`, then `last_bad <= k`.
- **End of window:**
  - `settle_cycles` = `last_bad`, with the sample-WINDOW compare included.
  - `timeout` = mismatch at k=WINDOW. On timeout, `settle_cycles` = WINDOW and `err_count` increments, saturating.
- **Maximum tracking:**
  - If `settle_cycles > max_settle` (strict), update `max_settle`, `max_from <= prev_code` and `max_to <= cur_code`.
  - On a tie, the first occurrence is kept.
- **Relaunch during TRACK:** the current measurement is discarded. There is no `done` and no max, err or settle update, and the new window starts.
- **Reset mid-TRACK:** all state clears immediately; no `done`.
- `ref_sum` and `dut_sum` are treated as combinational from the current code; no synchronizers are inside the block.

## Timing
- `launch` is sampled at edge t.
- Samples k=1..WINDOW are taken at edges t+1..t+WINDOW.
- At edge t+WINDOW, all result registers update and `done` rises.
- `done` falls at edge t+WINDOW+1 unless the window is re-entered.
- `busy` is high from edge t through edge t+WINDOW, low while `done` is high.
- Latency from `launch` to `done` is WINDOW cycles.
- `launch` is accepted in the `done` cycle, so back-to-back windows have a WINDOW+1 period with no dead cycle beyond DONE.
- `settle_cycles`, `timeout`, `max_*`, `err_count` and `glitch_cnt` hold their values until the next `done`.

## Configuration
- **Macro:** `MONITOR_GLITCH_CNT_EN`.
- **Defined:**
  - A per-window counter increments at every TRACK sample where `dut_sum` differs from its value on the previous edge. The first sample compares against the value captured at the launch edge.
  - The counter saturates at 2^CNT_W-1 and is registered to `glitch_cnt` at `done`.
- **Undefined:** `glitch_cnt` is tied to 0 and no counter logic is built.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n`=0 mid-run, then release.
  - Required: all outputs are 0; the next `launch` starts a clean window and `err_count` is 0.
- **Matched vector:**
  - Stimulus: `launch` with code 0x00→0x7F, `dut_sum`==`ref_sum` throughout.
  - Required: `done` exactly 15 cycles after launch; `settle_cycles`=0, `timeout`=0; `max_settle` stays 0.
- **Settling vector:**
  - Stimulus: `dut_sum` mismatches at k=1..4, then matches; transition 0x2A→0x55.
  - Required: `settle_cycles`=4, `max_settle`=4, `max_from`=0x2A, `max_to`=0x55.
- **Glitch:**
  - Stimulus: mismatch at k=2 and k=6 only, `MONITOR_GLITCH_CNT_EN` defined.
  - Required: `settle_cycles`=6, `glitch_cnt`=4.
  - Stimulus: a later vector settling at 6 again.
  - Required: `max_*` unchanged (strict compare).
- **Timeout:**
  - Stimulus: mismatch through k=15.
  - Required: `timeout`=1, `settle_cycles`=15, `err_count`=1, `max_settle`=15.
- **Relaunch and back-to-back:**
  - Stimulus: relaunch at k=5.
  - Required: no `done`; the next `done` is 15 cycles after the relaunch.
  - Stimulus: `launch` in the `done` cycle.
  - Required: accepted; `busy` high on the next cycle.

Source files
------------

// File: rtl/adder_settle_monitor.sv
// rtl/adder_settle_monitor.sv - clocked settle-time monitor for gate-level adder characterization
// Optional per-window glitch counter: define MONITOR_GLITCH_CNT_EN.
module adder_settle_monitor #(
  parameter int WIDTH  = 3,
  parameter int WINDOW = 15,
  parameter int CNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               launch,
  input  logic [2*WIDTH:0]   launch_code,
  input  logic [WIDTH:0]     ref_sum,
  input  logic [WIDTH:0]     dut_sum,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   settle_cycles,
  output logic               timeout,
  output logic [CNT_W-1:0]   max_settle,
  output logic [2*WIDTH:0]   max_from,
  output logic [2*WIDTH:0]   max_to,
  output logic [15:0]        err_count,
  output logic [CNT_W-1:0]   glitch_cnt
);

  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   k_q, last_bad_q;
  logic [2*WIDTH:0]   prev_code_q, cur_code_q;
  logic               busy_q, done_q, timeout_q;
  logic [CNT_W-1:0]   settle_q, max_settle_q;
  logic [2*WIDTH:0]   max_from_q, max_to_q;
  logic [15:0]        err_q;

  logic               mismatch;
  logic [CNT_W-1:0]   k_d;
  logic               last_sample;
  logic [CNT_W-1:0]   settle_d;

  assign mismatch    = (dut_sum != ref_sum);
  assign k_d         = k_q + 1'b1;
  assign last_sample = (state_q == TRACK) && (k_d == WIN);
  // A mismatch on the final sample makes last_bad equal WINDOW, i.e. a timeout.
  assign settle_d    = mismatch ? WIN : last_bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      last_bad_q   <= '0;
      prev_code_q  <= '0;
      cur_code_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      settle_q     <= '0;
      max_settle_q <= '0;
      max_from_q   <= '0;
      max_to_q     <= '0;
      err_q        <= '0;
    end else begin
      done_q <= 1'b0;
      if (launch) begin
        state_q     <= TRACK;
        busy_q      <= 1'b1;
        k_q         <= '0;
        last_bad_q  <= '0;
        prev_code_q <= cur_code_q;
        cur_code_q  <= launch_code;
      end else begin
        case (state_q)
          TRACK: begin
            k_q <= k_d;
            if (mismatch) last_bad_q <= k_d;
            if (last_sample) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              settle_q  <= settle_d;
              timeout_q <= mismatch;
              if (mismatch && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
              if (settle_d > max_settle_q) begin
                max_settle_q <= settle_d;
                max_from_q   <= prev_code_q;
                max_to_q     <= cur_code_q;
              end
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef MONITOR_GLITCH_CNT_EN
  logic [WIDTH:0]   dut_prev_q;
  logic [CNT_W-1:0] gcnt_q, gcnt_d, glitch_q;

  always_comb begin
    gcnt_d = gcnt_q;
    if ((dut_sum != dut_prev_q) && (gcnt_q != {CNT_W{1'b1}})) gcnt_d = gcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_prev_q <= '0;
      gcnt_q     <= '0;
      glitch_q   <= '0;
    end else if (launch) begin
      dut_prev_q <= dut_sum;
      gcnt_q     <= '0;
    end else if (state_q == TRACK) begin
      dut_prev_q <= dut_sum;
      gcnt_q     <= gcnt_d;
      if (last_sample) glitch_q <= gcnt_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign settle_cycles = settle_q;
  assign timeout       = timeout_q;
  assign max_settle    = max_settle_q;
  assign max_from      = max_from_q;
  assign max_to        = max_to_q;
  assign err_count     = err_q;

endmodule
